// File: rtl/mmffisc_bank.sv
// mmffisc_bank: WIDTH-channel bank of configurable scan flip-flops.
// Each channel has 4 config bits (reg_en, init, clr_en, inv) loaded through
// one serial chain; functional outputs stay at 0 until a complete load.
module mmffisc_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             cfg_en_i,
   input  logic             cfg_d_i,
   output logic             cfg_q_o,
   output logic             cfg_done_o,
   input  logic             se_i,
   input  logic             si_i,
   output logic             so_o,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] clr_i,
   output logic [WIDTH-1:0] q_o
);

   localparam int CFG_BITS = 4;
   localparam int N        = WIDTH * CFG_BITS;
   localparam int CNT_W    = $clog2(N + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [N-1:0]     cfg_q, cfg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reg_q, reg_d;

   logic [WIDTH-1:0] reg_en, init_v, clr_en, inv;
   // Scan path: bit 0 is the serial input, bit WIDTH is the last register.
   logic [WIDTH:0]   scan_vec;
   logic             done;

   // Per-channel fields of the flat configuration chain (channel c at c*4+b).
   for (genvar c = 0; c < WIDTH; c++) begin : g_chan
      assign reg_en[c] = cfg_q[c*CFG_BITS + 0];
      assign init_v[c] = cfg_q[c*CFG_BITS + 1];
      assign clr_en[c] = cfg_q[c*CFG_BITS + 2];
      assign inv[c]    = cfg_q[c*CFG_BITS + 3];
   end

   assign scan_vec = {reg_q, si_i};
   assign done     = (cnt_q == CNT_FULL);

   // Config chain shift and load counter; a shift while full restarts at 1.
   always_comb begin
      cfg_d = cfg_q;
      cnt_d = cnt_q;
      if (cfg_en_i) begin
         cfg_d = {cfg_q[N-2:0], cfg_d_i};
         cnt_d = (cnt_q == CNT_FULL) ? CNT_ONE : cnt_q + CNT_ONE;
      end
   end

   // Data register next state: scan, then gated clear, then capture, else hold.
   always_comb begin
      reg_d = reg_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (se_i) begin
            reg_d[i] = scan_vec[i];
         end else if (clr_i[i] && clr_en[i]) begin
            reg_d[i] = init_v[i];
         end else if (reg_en[i]) begin
            reg_d[i] = d_i[i];
         end
      end
   end

   // State registers with synchronous reset; reset also discards a partial load.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cfg_q <= '0;
         cnt_q <= '0;
         reg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
         cnt_q <= cnt_d;
         reg_q <= reg_d;
      end
   end

   assign cfg_q_o    = cfg_q[N-1];
   assign cfg_done_o = done;
   assign so_o       = scan_vec[WIDTH];
   // Bypass channels pass d_i combinationally; outputs are gated until loaded.
   assign q_o        = done ? (((reg_en & reg_q) | (~reg_en & d_i)) ^ inv) : '0;

endmodule

// File: tb/tb_mmffisc_bank.sv
// Self-checking bench for mmffisc_bank (WIDTH=4, chain length 16).
// Reference model: the config chain is the list of bits shifted since reset,
// done is "shift count is a nonzero multiple of 16".
module tb_mmffisc_bank;

   localparam int W = 4;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         srst = 1'b0;
   logic         cfg_en = 1'b0;
   logic         cfg_d = 1'b0;
   logic         cfg_q;
   logic         cfg_done;
   logic         se = 1'b0;
   logic         si = 1'b0;
   logic         so;
   logic [W-1:0] d = '0;
   logic [W-1:0] clr = '0;
   logic [W-1:0] q;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state
   bit           hist[$];
   logic [W-1:0] m_reg = '0;

   mmffisc_bank #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .srst_i     (srst),
      .cfg_en_i   (cfg_en),
      .cfg_d_i    (cfg_d),
      .cfg_q_o    (cfg_q),
      .cfg_done_o (cfg_done),
      .se_i       (se),
      .si_i       (si),
      .so_o       (so),
      .d_i        (d),
      .clr_i      (clr),
      .q_o        (q)
   );

   always #5 clk = ~clk;

   // Chain index k holds the bit shifted in k shifts ago (0 if none yet).
   function automatic logic cfg_bit(input int k);
      if (hist.size() > k) return hist[hist.size() - 1 - k];
      return 1'b0;
   endfunction

   function automatic logic exp_done();
      return (hist.size() > 0) && (hist.size() % N == 0);
   endfunction

   function automatic logic [W-1:0] exp_q();
      logic [W-1:0] r;
      r = '0;
      if (exp_done())
         for (int i = 0; i < W; i++)
            r[i] = (cfg_bit(i*4) ? m_reg[i] : d[i]) ^ cfg_bit(i*4 + 3);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_cfgq"}, 32'(cfg_q), 32'(cfg_bit(N-1)));
      chk({tag, "_done"}, 32'(cfg_done), 32'(exp_done()));
      chk({tag, "_so"}, 32'(so), 32'(m_reg[W-1]));
      chk({tag, "_q"}, 32'(q), 32'(exp_q()));
   endtask

   // One clock: compute model next state from the current inputs, then compare.
   task automatic tick(input string tag);
      logic [W-1:0] nreg;
      nreg = m_reg;
      if (srst) nreg = '0;
      else if (se) nreg = {m_reg[W-2:0], si};
      else begin
         for (int i = 0; i < W; i++) begin
            if (clr[i] && cfg_bit(i*4 + 2)) nreg[i] = cfg_bit(i*4 + 1);
            else if (cfg_bit(i*4)) nreg[i] = d[i];
         end
      end
      @(posedge clk);
      if (srst) hist.delete();
      else if (cfg_en) hist.push_back(cfg_d);
      m_reg = nreg;
      #1;
      check_all(tag);
   endtask

   // Shift a full 16-bit word, channel 3 bit 3 (index 15) first.
   task automatic load(input logic [15:0] w, input string tag);
      for (int k = N - 1; k >= 0; k--) begin
         cfg_en = 1'b1;
         cfg_d  = w[k];
         tick(tag);
      end
      cfg_en = 1'b0;
      cfg_d  = 1'b0;
   endtask

   initial begin
      logic [3:0] si_pat;
      logic [3:0] so_seen;

      // 1. Reset with random inputs
      cfg_en = 1'($urandom); cfg_d = 1'($urandom); se = 1'($urandom);
      si = 1'($urandom); d = 4'($urandom); clr = 4'($urandom);
      srst = 1'b1;
      tick("rst");
      srst = 1'b0; cfg_en = 1'b0; se = 1'b0; clr = '0; d = 4'hF;
      #1;
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_cfgq", 32'(cfg_q), 32'd0);
      chk("rst_so", 32'(so), 32'd0);
      chk("rst_q_dF", 32'(q), 32'd0);

      // 2. Full load: ch0 registered, ch1 bypass+invert
      d = 4'($urandom);
      for (int k = N - 1; k >= 0; k--) begin
         cfg_en = 1'b1;
         cfg_d  = 1'(16'h0081 >> k);
         tick("load1");
         chk("load1_done_edge", 32'(cfg_done), 32'(k == 0));
      end
      cfg_en = 1'b0;
      d = 4'b0011;
      #1;
      chk("byp_same_cycle_q1", 32'(q[1]), 32'd0);
      tick("reg_lat");
      chk("reg_lat_q0", 32'(q[0]), 32'd1);

      // 3. Clear: ch2 = registered, init 1, clr_en 1
      load(16'h0781, "load2");
      d = 4'b0000; clr = '0;
      tick("clr_pre");
      chk("clr_pre_q2", 32'(q[2]), 32'd0);
      clr = 4'b0100;
      tick("clr2");
      chk("clr2_q2", 32'(q[2]), 32'd1);
      clr = '0; d = 4'b0001;
      tick("clr0_pre");
      clr = 4'b0001;
      tick("clr0");
      chk("clr0_ignored_q0", 32'(q[0]), 32'd1);
      clr = '0;

      // 4. Scan 1,0,1,1 with clear held high
      si_pat = 4'b1101;   // sent LSB first: 1,0,1,1
      so_seen = '0;
      se = 1'b1; clr = 4'hF;
      for (int t = 0; t < 7; t++) begin
         si = (t < 4) ? si_pat[t] : 1'b0;
         tick("scan");
         if (t >= 3) so_seen[t-3] = so;
      end
      chk("scan_so_seq", 32'(so_seen), 32'(si_pat));
      se = 1'b0; clr = '0; si = 1'b0;

      // 5. Reconfiguration restart
      d = 4'hF;
      cfg_en = 1'b1; cfg_d = 1'b0;
      tick("restart");
      chk("restart_done", 32'(cfg_done), 32'd0);
      chk("restart_q", 32'(q), 32'd0);
      for (int k = 1; k < N; k++) begin
         cfg_d = 1'($urandom);
         tick("reload");
         chk("reload_done", 32'(cfg_done), 32'(k == N - 1));
      end
      cfg_en = 1'b0;

      // 6. Reset mid-load discards the partial load
      load(16'hFFFF, "ones");
      for (int k = 0; k < 9; k++) begin
         cfg_en = 1'b1; cfg_d = 1'b1;
         tick("mid");
      end
      chk("mid_cfgq_before", 32'(cfg_q), 32'd1);
      srst = 1'b1;     // cfg_en still high: reset must win
      tick("midrst");
      srst = 1'b0;
      chk("midrst_cfgq", 32'(cfg_q), 32'd0);
      chk("midrst_done", 32'(cfg_done), 32'd0);
      for (int k = 1; k <= N; k++) begin
         cfg_en = 1'b1; cfg_d = 1'($urandom);
         tick("after_rst");
         chk("after_rst_done", 32'(cfg_done), 32'(k == N));
      end
      cfg_en = 1'b0;

      // Random traffic against the model
      for (int t = 0; t < 400; t++) begin
         srst   = ($urandom_range(0, 59) == 0);
         cfg_en = 1'($urandom);
         cfg_d  = 1'($urandom);
         se     = ($urandom_range(0, 3) == 0);
         si     = 1'($urandom);
         d      = 4'($urandom);
         clr    = 4'($urandom);
         tick("rand");
         d = 4'($urandom);
         #1;
         chk("rand_byp_q", 32'(q), 32'(exp_q()));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
